// File: rtl/palette_ram.sv
// Double-buffered colour palette: lookups read the front bank, writes fill the back bank,
// and a swap armed by swap_req takes effect at the next frame_start. Output is faded per channel.
module palette_ram #(
    parameter int INDEX_W = 3,
    parameter int CH_W    = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 wr_en,
    input  logic [INDEX_W-1:0]   wr_addr,
    input  logic [3*CH_W-1:0]    wr_data,
    input  logic                 swap_req,
    input  logic                 frame_start,
    input  logic [CH_W-1:0]      fade_target,
    input  logic                 rd_valid,
    input  logic [INDEX_W-1:0]   palette_index,
    output logic [3*CH_W-1:0]    color,
    output logic                 color_valid,
    output logic                 active_bank,
    output logic                 swap_pending,
    output logic [CH_W-1:0]      fade_level
);

    localparam int DEPTH  = 2 ** INDEX_W;
    localparam int STAGES = 2;

    logic [3*CH_W-1:0] mem [0:1][0:DEPTH-1];
    logic [3*CH_W-1:0] s1_data;
    logic [3*CH_W-1:0] faded;
    logic [STAGES:1]   vld_pipe;
    logic              do_swap;

    // Reset table nibbles sit in the channel MSBs so wider channels keep the same hue.
    function automatic logic [3*CH_W-1:0] default_entry(input int idx);
        logic [11:0] nib;
        logic [CH_W-1:0] r, g, b;
        case (idx)
            0:       nib = 12'h8CF;
            1:       nib = 12'hB86;
            2:       nib = 12'hB74;
            3:       nib = 12'hA75;
            4:       nib = 12'h974;
            5:       nib = 12'h964;
            6:       nib = 12'h655;
            7:       nib = 12'h432;
            default: nib = 12'h000;
        endcase
        r = CH_W'(nib[11:8]) << (CH_W - 4);
        g = CH_W'(nib[7:4])  << (CH_W - 4);
        b = CH_W'(nib[3:0])  << (CH_W - 4);
        return {r, g, b};
    endfunction

    assign do_swap = frame_start && (swap_pending || swap_req);

    // Bank storage; the write target is the bank that is back before any swap at this edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[b][i] <= default_entry(i);
                end
            end
        end else if (wr_en) begin
            mem[~active_bank][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            active_bank  <= 1'b0;
            swap_pending <= 1'b0;
        end else if (do_swap) begin
            active_bank  <= ~active_bank;
            swap_pending <= 1'b0;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fade_level <= '0;
        end else if (frame_start) begin
            if (fade_level < fade_target) begin
                fade_level <= fade_level + 1'b1;
            end else if (fade_level > fade_target) begin
                fade_level <= fade_level - 1'b1;
            end
        end
    end

    // Saturating subtract per channel.
    always_comb begin
        faded = '0;
        for (int c = 0; c < 3; c++) begin
            if (s1_data[c*CH_W +: CH_W] > fade_level) begin
                faded[c*CH_W +: CH_W] = s1_data[c*CH_W +: CH_W] - fade_level;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_pipe <= '0;
            s1_data  <= '0;
            color    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], rd_valid};
            if (rd_valid) begin
                s1_data <= mem[active_bank][palette_index];
            end
            if (vld_pipe[1]) begin
                color <= faded;
            end
        end
    end

    assign color_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_palette_ram.sv
// Directed bench for palette_ram: expected colours are queued when a lookup is issued
// and checked (value and arrival cycle) when color_valid appears.
module tb_palette_ram;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [11:0] wr_data;
    logic        swap_req;
    logic        frame_start;
    logic [3:0]  fade_target;
    logic        rd_valid;
    logic [2:0]  palette_index;
    logic [11:0] color;
    logic        color_valid;
    logic        active_bank;
    logic        swap_pending;
    logic [3:0]  fade_level;

    logic        w_wr_en = 1'b0;
    logic [4:0]  w_wr_addr = '0;
    logic [23:0] w_wr_data = '0;
    logic        w_swap_req = 1'b0;
    logic        w_frame_start = 1'b0;
    logic [7:0]  w_fade_target = '0;
    logic        w_rd_valid;
    logic [4:0]  w_index;
    logic [23:0] w_color;
    logic        w_color_valid;
    logic        w_active_bank;
    logic        w_swap_pending;
    logic [7:0]  w_fade_level;

    typedef struct {
        logic [11:0] col;
        int          due;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 Clk = ~Clk;

    palette_ram dut (
        .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap_req(swap_req), .frame_start(frame_start), .fade_target(fade_target),
        .rd_valid(rd_valid), .palette_index(palette_index), .color(color),
        .color_valid(color_valid), .active_bank(active_bank), .swap_pending(swap_pending),
        .fade_level(fade_level)
    );

    palette_ram #(.INDEX_W(5), .CH_W(8)) dut_w (
        .Clk(Clk), .Reset(Reset), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .swap_req(w_swap_req), .frame_start(w_frame_start), .fade_target(w_fade_target),
        .rd_valid(w_rd_valid), .palette_index(w_index), .color(w_color),
        .color_valid(w_color_valid), .active_bank(w_active_bank), .swap_pending(w_swap_pending),
        .fade_level(w_fade_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then drain/verify the scoreboard against the new outputs.
    task automatic step();
        exp_t e;
        @(posedge Clk);
        #1;
        cyc++;
        if (color_valid) begin
            tests++;
            assert (q.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_valid: got color %0h at cycle %0d expected no valid", color, cyc);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("color", 32'(color), 32'(e.col));
                chk("latency", 32'(cyc), 32'(e.due));
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            tests++;
            assert (q[0].due > cyc) else begin
                fails++;
                $error("FAIL missing_valid: got none at cycle %0d expected color %0h", cyc, q[0].col);
            end
            void'(q.pop_front());
        end
    endtask

    task automatic read(input logic [2:0] idx, input logic [11:0] exp);
        exp_t e;
        rd_valid = 1'b1;
        palette_index = idx;
        e.col = exp;
        e.due = cyc + 2;
        q.push_back(e);
        step();
        rd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic write(input logic [2:0] a, input logic [11:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    logic [11:0] deftab [0:7];

    initial begin
        deftab = '{12'h8CF, 12'hB86, 12'hB74, 12'hA75, 12'h974, 12'h964, 12'h655, 12'h432};
        // Reset with every other input active: reset must dominate.
        Reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 12'hFFF;
        swap_req = 1'b1; frame_start = 1'b1; fade_target = 4'd5;
        rd_valid = 1'b1; palette_index = 3'd0; w_rd_valid = 1'b0; w_index = '0;
        step(); step(); step();
        wr_en = 1'b0; swap_req = 1'b0; frame_start = 1'b0; rd_valid = 1'b0; fade_target = 4'd0;
        step();
        chk("rst_active_bank", 32'(active_bank), 0);
        chk("rst_swap_pending", 32'(swap_pending), 0);
        chk("rst_fade_level", 32'(fade_level), 0);
        chk("rst_color_valid", 32'(color_valid), 0);
        chk("rst_color", 32'(color), 0);
        Reset = 1'b0;
        step(); step();

        // Back-to-back lookups of the default table.
        read(3'd0, 12'h8CF);
        read(3'd7, 12'h432);
        drain();
        chk("color_hold", 32'(color), 32'h432);
        for (int i = 1; i < 7; i++) read(3'(i), deftab[i]);
        drain();

        // Back-bank write, armed swap, repeated swap_req, then frame_start.
        write(3'd2, 12'hF00);
        read(3'd2, 12'hB74);
        drain();
        swap_req = 1'b1; step(); swap_req = 1'b0;
        chk("armed_pending", 32'(swap_pending), 1);
        chk("armed_bank", 32'(active_bank), 0);
        swap_req = 1'b1; step(); swap_req = 1'b0;
        chk("rearm_pending", 32'(swap_pending), 1);
        chk("rearm_bank", 32'(active_bank), 0);
        frame_start = 1'b1; step(); frame_start = 1'b0;
        chk("swap_bank", 32'(active_bank), 1);
        chk("swap_pending_clr", 32'(swap_pending), 0);
        read(3'd2, 12'hF00);
        read(3'd3, 12'hA75);
        drain();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        chk("idle_frame_bank", 32'(active_bank), 1);

        // Same-cycle swap_req + frame_start + write: write lands in the bank that becomes front.
        swap_req = 1'b1; frame_start = 1'b1;
        write(3'd5, 12'h0F0);
        swap_req = 1'b0; frame_start = 1'b0;
        chk("sameswap_bank", 32'(active_bank), 0);
        chk("sameswap_pending", 32'(swap_pending), 0);
        read(3'd5, 12'h0F0);
        read(3'd2, 12'hB74);
        drain();
        // Back-bank write is invisible to the front bank.
        write(3'd0, 12'h123);
        read(3'd0, 12'h8CF);
        drain();
        // Swap at the same edge as a lookup: the lookup keeps the old bank.
        swap_req = 1'b1; frame_start = 1'b1;
        read(3'd0, 12'h8CF);
        swap_req = 1'b0; frame_start = 1'b0;
        read(3'd0, 12'h123);
        drain();
        chk("inflight_swap_bank", 32'(active_bank), 1);

        // Fade stepping and clamp.
        fade_target = 4'd3;
        for (int i = 0; i < 4; i++) begin
            frame_start = 1'b1; step(); frame_start = 1'b0;
            chk("fade_step", 32'(fade_level), (i < 3) ? i + 1 : 3);
        end
        read(3'd7, 12'h100);
        read(3'd2, 12'hC00);
        drain();
        fade_target = 4'd1;
        frame_start = 1'b1; step(); frame_start = 1'b0;
        chk("fade_down", 32'(fade_level), 2);

        // Reset with a pending swap, non-zero fade and a lookup in flight.
        swap_req = 1'b1; step(); swap_req = 1'b0;
        chk("pre_rst_pending", 32'(swap_pending), 1);
        rd_valid = 1'b1; palette_index = 3'd2; step(); rd_valid = 1'b0;
        Reset = 1'b1; fade_target = 4'd0; step();
        chk("rst2_color_valid", 32'(color_valid), 0);
        step();
        Reset = 1'b0;
        chk("rst2_bank", 32'(active_bank), 0);
        chk("rst2_pending", 32'(swap_pending), 0);
        chk("rst2_fade", 32'(fade_level), 0);
        chk("rst2_color", 32'(color), 0);
        step(); step();
        chk("rst2_no_valid", 32'(color_valid), 0);
        read(3'd0, 12'h8CF);
        drain();
        swap_req = 1'b1; frame_start = 1'b1; step(); swap_req = 1'b0; frame_start = 1'b0;
        read(3'd2, 12'hB74);
        read(3'd0, 12'h8CF);
        drain();

        // Wide configuration.
        w_rd_valid = 1'b1; w_index = 5'd20; step(); w_rd_valid = 1'b0; step();
        chk("wide_valid", 32'(w_color_valid), 1);
        chk("wide_idx20", 32'(w_color), 32'h000000);
        w_rd_valid = 1'b1; w_index = 5'd0; step(); w_rd_valid = 1'b0; step();
        chk("wide_idx0", 32'(w_color), 32'h80C0F0);
        step();
        chk("wide_valid_drop", 32'(w_color_valid), 0);

        chk("queue_empty", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/palette_ram.md
PALETTE_RAM -- requirements
Module: palette_ram

Interface
REQ-001 The block SHALL have the parameter INDEX_W, default 3, meaning palette index width; depth is 2**INDEX_W entries per bank.
REQ-002 The block SHALL have the parameter CH_W, default 4, meaning bits per colour channel; CH_W >= 4 is required.
REQ-003 Clk  input  1  -- the only clock; all state changes on its rising edge.
REQ-004 Reset  input  1  -- synchronous, active-high reset.
REQ-005 wr_en  input  1  -- write strobe to the back bank.
REQ-006 wr_addr  input  INDEX_W  -- entry to write.
REQ-007 wr_data  input  3*CH_W  -- packed {r,g,b}, r in the MSBs.
REQ-008 swap_req  input  1  -- one-cycle pulse requesting a front/back bank swap.
REQ-009 frame_start  input  1  -- one-cycle pulse at the vertical blanking start.
REQ-010 fade_target  input  CH_W  -- requested darkening amount.
REQ-011 rd_valid  input  1  -- lookup request qualifier.
REQ-012 palette_index  input  INDEX_W  -- lookup index.
REQ-013 color  output  3*CH_W  -- packed {r,g,b} lookup result.
REQ-014 color_valid  output  1  -- qualifies color.
REQ-015 active_bank  output  1  -- bank currently used for lookups.
REQ-016 swap_pending  output  1  -- a swap is armed and waiting for frame_start.
REQ-017 fade_level  output  CH_W  -- fade amount currently applied.

Function
REQ-018 The block SHALL hold two banks (0, 1) of 2**INDEX_W entries, each 3*CH_W bits wide; the front bank is active_bank and the back bank is ~active_bank.
REQ-019 Writes with wr_en=1 SHALL update back-bank entry wr_addr at the clock edge; the front bank SHALL never be written.
REQ-020 A write in the same cycle as a swap SHALL target the bank that was back at the start of that cycle.
REQ-021 swap_req SHALL set swap_pending; repeated swap_req pulses while pending SHALL have no additional effect.
REQ-022 On frame_start with swap_pending=1, or with swap_req=1 in the same cycle, active_bank SHALL toggle and swap_pending SHALL clear at that edge.
REQ-023 A frame_start with no pending or same-cycle swap_req SHALL leave active_bank unchanged.
REQ-024 On each frame_start, fade_level SHALL step by exactly 1 toward fade_target: increment if below, decrement if above, hold if equal.
REQ-025 Lookup SHALL be a 2-stage pipeline with fixed 2-cycle latency and no stall:
- Stage 1 registers the raw entry of the bank that is active at the rd_valid edge.
- Stage 2 registers the faded result.
- color_valid equals rd_valid delayed by 2 cycles.
REQ-026 Each output channel SHALL equal max(channel - fade_level, 0), using the fade_level value present when stage 2 registers; there SHALL be no wrap-around below zero.
REQ-027 A bank swap SHALL NOT alter data already inside the pipeline.
REQ-028 color SHALL hold its last value while color_valid=0.

Reset
REQ-029 While Reset=1, the following SHALL hold:
- active_bank=0, swap_pending=0, fade_level=0.
- color_valid=0, color=0, pipeline valid bits cleared.
- Both banks loaded with the default table.
REQ-030 The default table, for entries 0..7, SHALL be 8CF, B86, B74, A75, 974, 964, 655, 432 (r,g,b nibbles).
- For CH_W>4, each nibble occupies the channel MSBs, LSBs zero.
- Entries 8 and above reset to 0.
REQ-031 Reset SHALL take priority over all simultaneous wr_en, swap_req, frame_start and rd_valid.
- In-flight lookups are discarded.
- color_valid SHALL be 0 in the 2 cycles after Reset deasserts unless new reads are issued.

Verification
REQ-032 Default parameters, after reset, rd_valid with index 0 then 7 on consecutive cycles -> color 8CF then 432, each 2 cycles after its request, color_valid high for exactly 2 cycles.
REQ-033 Write 0xF00 to entry 2, then read index 2 before any swap -> B74. Then pulse swap_req, then frame_start, then read index 2 -> F00, and active_bank=1.
REQ-034 swap_req and frame_start in the same cycle, together with a write of 0x0F0 to entry 5 -> active_bank toggles. A read of entry 5 afterwards returns 0x0F0.
REQ-035 fade_target=3, then 4 frame_start pulses -> fade_level goes 1, 2, 3, 3. Reading index 7 at the end gives 0x100 (4-3, 3-3 clamped to 0, 2-3 clamped to 0).
REQ-036 Reset asserted while swap_pending=1, fade_level=2 and a read in flight -> outputs return to their reset values, no color_valid pulse appears, and the default table is restored.
REQ-037 INDEX_W=5, CH_W=8: read index 20 after reset -> 0x000000. Read index 0 -> 0x80C0F0.
